// File: rtl/array_mul_pkg.sv
// Shared types and sizing helpers for the sequential array multiplier.
// The state enum and width functions are used by array_mul_seq and array_mul_step.
package array_mul_pkg;

    // Controller states: idle, one add/sub-and-shift step per cycle, one-cycle result pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter width: it holds M-1 down to 0. Never narrower than one bit.
    function automatic int cnt_width(input int m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    // Result width: N+M bits is enough for an exact product in both modes.
    function automatic int res_width(input int n, input int m);
        return n + m;
    endfunction

endpackage

// File: rtl/array_mul_step.sv
// One combinational step of the sequential multiplier.
// Adds (or, for the signed MSB of B, subtracts) A, extended to N+M bits and
// shifted left by the bit index, to the running partial product.
module array_mul_step
    import array_mul_pkg::*;
#(
    parameter int N  = 8,
    parameter int M  = 8,
    parameter int CW = 3
) (
    input  logic [N+M-1:0] pp,
    input  logic [N-1:0]   a,
    input  logic           b_bit,
    input  logic [CW-1:0]  idx,
    input  logic           sg,
    input  logic           is_last,
    output logic [N+M-1:0] pp_next
);

    logic [N+M-1:0] a_ext;
    logic [N+M-1:0] term;

    // Sign-extend A in signed mode, zero-extend otherwise.
    assign a_ext = {{M{sg & a[N-1]}}, a};
    assign term  = a_ext << idx;

    // Select the next partial product: hold, add, or subtract the weighted term.
    always_comb begin
        pp_next = pp;
        if (b_bit) begin
            if (sg && is_last) begin
                // B's MSB carries negative weight in two's complement.
                pp_next = pp - term;
            end else begin
                pp_next = pp + term;
            end
        end
    end

endmodule

// File: rtl/array_mul_seq.sv
// Sequential N x M multiplier with run-time signed/unsigned selection.
// One partial-product step per clock; result after M+1 cycles.
// Optional feature: define ARRAY_MUL_ACC_EN to add the acc port and make the
// unit multiply-accumulate (Y = product + previous Y when acc=1).
//
// Handshake: start is sampled on a rising edge only while busy=0 (IDLE or DONE).
// The accepting edge latches A, B, sg (and acc); busy is high for the next M
// cycles; done then pulses for exactly one cycle with Y valid from that cycle.
// Y holds until the next done. A start in the DONE cycle is accepted back-to-back.
module array_mul_seq
    import array_mul_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef ARRAY_MUL_ACC_EN
    input  logic             acc,
`endif
    input  logic [N-1:0]     A,
    input  logic [M-1:0]     B,
    input  logic             sg,
    output logic             busy,
    output logic             done,
    output logic [N+M-1:0]   Y,
    output logic [1:0]       state_dbg
);

    localparam int W  = res_width(N, M);
    localparam int CW = cnt_width(M);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    pp;
    logic [W-1:0]    pp_next;
    logic [N-1:0]    a_r;
    logic [M-1:0]    b_r;
    logic            sg_r;
    logic [CW-1:0]   idx;
    logic            is_last;
    logic [W-1:0]    y_base;
`ifdef ARRAY_MUL_ACC_EN
    logic            acc_r;
`endif

    // Counter runs M-1 down to 0, bits of B are consumed LSB first.
    assign idx       = CW'(M - 1) - cnt;
    assign is_last   = (cnt == '0);
    assign state_dbg = state;

`ifdef ARRAY_MUL_ACC_EN
    assign y_base = acc_r ? Y : '0;
`else
    assign y_base = '0;
`endif

    array_mul_step #(
        .N  (N),
        .M  (M),
        .CW (CW)
    ) u_step (
        .pp      (pp),
        .a       (a_r),
        .b_bit   (b_r[idx]),
        .idx     (idx),
        .sg      (sg_r),
        .is_last (is_last),
        .pp_next (pp_next)
    );

    // Controller, operand latches, partial product and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Y     <= '0;
            cnt   <= '0;
            pp    <= '0;
            a_r   <= '0;
            b_r   <= '0;
            sg_r  <= 1'b0;
`ifdef ARRAY_MUL_ACC_EN
            acc_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= A;
                        b_r   <= B;
                        sg_r  <= sg;
`ifdef ARRAY_MUL_ACC_EN
                        acc_r <= acc;
`endif
                        pp    <= '0;
                        cnt   <= CW'(M - 1);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    pp <= pp_next;
                    if (is_last) begin
                        Y     <= pp_next + y_base;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_mul_seq.sv
// Self-checking bench for array_mul_seq (N=M=8): directed cases from the
// test plan plus randomised back-to-back operations against an arithmetic model.
module tb_array_mul_seq;
    import array_mul_pkg::*;

    localparam int N = 8;
    localparam int M = 8;
    localparam int W = N + M;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  a;
    logic [M-1:0]  b;
    logic          sg;
    logic          busy;
    logic          done;
    logic [W-1:0]  y;
    logic [1:0]    state_dbg;
`ifdef ARRAY_MUL_ACC_EN
    logic          acc;
`endif

    int            tests = 0;
    int            fails = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  y_model = '0;

    // Clock
    always #5 clk = ~clk;

    array_mul_seq #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef ARRAY_MUL_ACC_EN
        .acc       (acc),
`endif
        .A         (a),
        .B         (b),
        .sg        (sg),
        .busy      (busy),
        .done      (done),
        .Y         (y),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic product, truncated to W bits.
    function automatic logic [W-1:0] model_prod(input logic [N-1:0] aa, input logic [M-1:0] bb,
                                                input logic ss);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic [W-1:0]        ua;
        logic [W-1:0]        ub;
        sa = W'($signed(aa));
        sb = W'($signed(bb));
        ua = W'(aa);
        ub = W'(bb);
        if (ss) return W'(sa * sb);
        return W'(ua * ub);
    endfunction

    // Driver: one operation, start in the current cycle, wait (bounded) for done.
    task automatic run_op(input logic [N-1:0] aa, input logic [M-1:0] bb, input logic ss,
                          input logic ac, input bit ign);
        logic [W-1:0] e;
        logic [W-1:0] y_before;
        int           lat;
        int           bcnt;
        e = model_prod(aa, bb, ss) + (ac ? y_model : W'(0));
        exp_q.push_back(e);
        y_before = y_model;
        a = aa;
        b = bb;
        sg = ss;
`ifdef ARRAY_MUL_ACC_EN
        acc = ac;
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        a = N'($urandom);
        b = M'($urandom);
        sg = 1'($urandom);
`ifdef ARRAY_MUL_ACC_EN
        acc = 1'($urandom);
`endif
        lat = 1;
        bcnt = 0;
        while (!done && lat <= 3 * M) begin
            if (busy) bcnt++;
            if (lat == 2) check("y_hold", 32'(y), 32'(y_before));
            start = ign && (lat == 3 || lat == 5);
            step();
            lat++;
        end
        start = 1'b0;
        check("latency", lat, M + 1);
        check("busy_len", bcnt, M);
        check("busy_at_done", 32'(busy), 0);
        check("y", 32'(y), 32'(exp_q.pop_front()));
        y_model = e;
    endtask

    initial begin
        int dcnt;
        int lat;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        sg = 1'b0;
`ifdef ARRAY_MUL_ACC_EN
        acc = 1'b0;
`endif
        repeat (2) step();
        rst = 1'b0;
        check("rst_state", 32'(state_dbg), 32'(IDLE));

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            check("idle_busy", 32'(busy), 0);
            check("idle_done", 32'(done), 0);
            check("idle_y", 32'(y), 0);
            step();
        end

        // Directed products, back-to-back
        run_op(8'd255, 8'd255, 1'b0, 1'b0, 1'b0);
        check("y_fe01", 32'(y), 32'h0000FE01);
        run_op(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
        check("y_16384", 32'(y), 32'd16384);
        run_op(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
        check("y_m1", 32'(y), 32'h0000FFFF);
        run_op(8'h7F, 8'h80, 1'b1, 1'b0, 1'b0);
        check("y_m16256", 32'(y), 32'h0000C080);

        // Ignored starts during RUN
        run_op(8'd3, 8'd5, 1'b0, 1'b0, 1'b1);
        check("y_15", 32'(y), 32'd15);
        step();
        check("single_done", 32'(done), 0);
        check("no_restart", 32'(busy), 0);

        // Reset in the 4th RUN cycle discards the operation
        a = 8'd7;
        b = 8'd9;
        sg = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        while (lat < 4) begin
            step();
            lat++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_run_busy", 32'(busy), 0);
        check("rst_run_done", 32'(done), 0);
        check("rst_run_y", 32'(y), 0);
        dcnt = 0;
        repeat (M + 2) begin
            if (done || busy) dcnt++;
            step();
        end
        check("rst_no_done", dcnt, 0);
        y_model = '0;

        // rst and start together: start dropped
        rst = 1'b1;
        start = 1'b1;
        a = 8'd5;
        b = 8'd5;
        step();
        rst = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 0);
        check("rst_start_state", 32'(state_dbg), 32'(IDLE));
        step();
        check("rst_start_busy2", 32'(busy), 0);

`ifdef ARRAY_MUL_ACC_EN
        // Multiply-accumulate
        run_op(8'd10, 8'd10, 1'b0, 1'b0, 1'b0);
        check("acc_100", 32'(y), 32'd100);
        run_op(8'd2, 8'd3, 1'b0, 1'b1, 1'b0);
        check("acc_106", 32'(y), 32'd106);
`endif

        // Randomised back-to-back operations in both modes
        for (int i = 0; i < 200; i++) begin
`ifdef ARRAY_MUL_ACC_EN
            run_op(N'($urandom), M'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0);
`else
            run_op(N'($urandom), M'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
`endif
        end
        step();
        check("final_done", 32'(done), 0);
        check("final_y_hold", 32'(y), 32'(y_model));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
